snn_frame_sequencer: RTL and testbench
======================================

Name: snn_frame_sequencer

Overview:
- Front-end controller for snn_core.
- Receives one 28x28 binary image as a packed byte stream and unpacks it into the 784x1 input RAM (DATA_WIDTH 1, ADDR_WIDTH 10).
- Pulses start to snn_core, arbitrates the RAM address port between its loader and the core's addr_input_unit, and captures the classified digit on done.
- Sits between the byte receiver (UART/host) and snn_core plus its input RAM.

Parameters:
- NUM_PIXELS, 784, pixels per frame; must be a multiple of 8.
- NUM_BYTES, NUM_PIXELS/8 = 98, bytes per frame (derived localparam).
- TIMEOUT_CYCLES, 2^20, max cycles to wait for core_done; used only with the optional feature.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- rx_rdy  in  1  byte available on rx_data; held until acked
- rx_data  in  8  packed pixels, bit0 = lowest pixel address
- rx_ack  out  1  one-cycle pulse, byte consumed
- core_start  out  1  one-cycle start pulse to snn_core
- core_done  in  1  snn_core done
- core_digit  in  4  snn_core digit
- core_addr  in  10  snn_core addr_input_unit
- ram_addr  out  10  input RAM address
- ram_we  out  1  input RAM write enable
- ram_wdata  out  1  input RAM write data
- result_vld  out  1  one-cycle pulse, result_digit updated
- result_digit  out  4  last classified digit
- busy  out  1  high in every state except IDLE
- timeout_err  out  1  sticky watchdog flag; tied 0 when feature absent

Behaviour:
- Reset values: rx_ack=0, core_start=0, ram_we=0, ram_wdata=0, result_vld=0, result_digit=0, busy=0, timeout_err=0. State=IDLE. Byte and bit counters=0.
- States: IDLE, LOAD, START, WAIT_DONE, RESULT.
- IDLE, rx_rdy=1: capture rx_data into shift register, reset byte_cnt to 0, go to LOAD. rx_ack pulses the cycle after capture.
- LOAD writes:
  - The cycle after capture, write bit0 to addr byte_cnt*8.
  - Then one bit per cycle for 8 consecutive cycles (ram_we=1), addr = byte_cnt*8 + bit_cnt, LSB first.
- LOAD next byte:
  - Earliest capture is on the edge ending the 8th write, so sustained throughput is 8 cycles/byte with no write gaps.
  - rx_rdy during cycles 1-7 of an unpack is not acked; the sender holds it.
- Address arithmetic is 10-bit; last frame byte (byte_cnt=97) writes addr 776..783. No wrap within a frame.
- After the 8th write of byte NUM_BYTES-1, go to START. ram_we=0 from that point.
- START: core_start=1 for exactly one cycle, then WAIT_DONE.
- WAIT_DONE: ram_addr = core_addr (combinational mux), ram_we=0.
  - On core_done=1: latch core_digit into result_digit, go to RESULT.
- ram_addr in all other states = loader address.
- RESULT: result_vld=1 for one cycle, then IDLE. result_digit holds until the next RESULT.
- rx_rdy in START/WAIT_DONE/RESULT is ignored (no ack).
- core_done outside WAIT_DONE is ignored. A done in the same cycle as the transition into WAIT_DONE counts.
- rst asserted mid-frame: immediate return to IDLE with all outputs at reset values. A partial frame is discarded; the next frame restarts at addr 0. The RAM is not cleared.

Optional Feature:
- Macro SNN_SEQ_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in WAIT_DONE.
  - Reaching TIMEOUT_CYCLES without core_done sets timeout_err (sticky until rst) and returns to IDLE without a result_vld pulse.
  - The counter clears on entry to WAIT_DONE.
- Undefined: no counter; WAIT_DONE waits indefinitely; timeout_err is constant 0.

Decomposition:
- Package snn_seq_pkg holds:
  - enum seq_state_t {IDLE, LOAD, START, WAIT_DONE, RESULT};
  - localparams PIX_ADDR_W=10 and DIGIT_W=4.
- One sub-module, snn_byte_unpacker: 8-bit shift register, bit counter, load/ack/busy handshake, emits per-bit write strobes. The FSM and address mux stay in the top.

Test Plan:
- 98 bytes of 0x00 back-to-back; core model returns digit 7 after 100 cycles:
  - 784 writes, addr 0..783, data 0;
  - core_start one cycle after the last write;
  - result_vld one cycle with result_digit=7; busy falls afterwards.
- First byte 0xA5, then 97 bytes 0xFF:
  - addr0..7 data 1,0,1,0,0,1,0,1; addr 8..783 data 1;
  - exactly one rx_ack per byte although rx_rdy is held high continuously.
- During WAIT_DONE, drive core_addr=0x2AB -> ram_addr=0x2AB, ram_we=0. Pulse rx_rdy -> no rx_ack.
- Assert rst after byte 40 -> outputs at reset values. A fresh 98-byte frame writes starting at addr 0 and completes with a correct result_vld.
- core_done pulsed in IDLE -> no result_vld, result_digit unchanged.
- With SNN_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=64, core never asserts done -> timeout_err=1 after 64 cycles, state IDLE, no result_vld.

Source files
------------

// File: rtl/snn_seq_pkg.sv
// Shared types and widths for the snn_core frame sequencer.
package snn_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT_DONE,
        RESULT
    } seq_state_t;

    localparam int unsigned PIX_ADDR_W = 10;
    localparam int unsigned DIGIT_W    = 4;

endpackage

// File: rtl/snn_byte_unpacker.sv
// Byte-to-bit unpacker: captures one packed byte and emits it LSB first, one bit per cycle.
module snn_byte_unpacker (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] data,
    output logic       ack,
    output logic       busy,
    output logic       ready,
    output logic       last_bit,
    output logic [2:0] bit_idx,
    output logic       bit_data
);

    logic [7:0] shreg;
    logic [2:0] bit_cnt;
    logic       active;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg   <= '0;
            bit_cnt <= '0;
            active  <= 1'b0;
            ack     <= 1'b0;
        end else begin
            ack <= load;
            if (load) begin
                shreg   <= data;
                bit_cnt <= '0;
                active  <= 1'b1;
            end else if (active) begin
                shreg   <= shreg >> 1;
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    active <= 1'b0;
                end
            end
        end
    end

    // A new byte may be taken on the edge that ends the 8th bit, so writes never gap.
    assign last_bit = active && (bit_cnt == 3'd7);
    assign ready    = !active || (bit_cnt == 3'd7);
    assign busy     = active;
    assign bit_idx  = bit_cnt;
    assign bit_data = shreg[0];

endmodule

// File: rtl/snn_frame_sequencer.sv
// snn_core front end: unpacks a byte-stream frame into the input RAM, starts the core, captures the digit.
// Optional core_done watchdog enabled by defining SNN_SEQ_TIMEOUT_EN.
module snn_frame_sequencer
    import snn_seq_pkg::*;
#(
    parameter int unsigned NUM_PIXELS = 784
`ifdef SNN_SEQ_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 2**20
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_rdy,
    input  logic [7:0]            rx_data,
    output logic                  rx_ack,
    output logic                  core_start,
    input  logic                  core_done,
    input  logic [DIGIT_W-1:0]    core_digit,
    input  logic [PIX_ADDR_W-1:0] core_addr,
    output logic [PIX_ADDR_W-1:0] ram_addr,
    output logic                  ram_we,
    output logic                  ram_wdata,
    output logic                  result_vld,
    output logic [DIGIT_W-1:0]    result_digit,
    output logic                  busy,
    output logic                  timeout_err
);

    localparam int unsigned NUM_BYTES = NUM_PIXELS / 8;
    localparam int unsigned BCW       = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

    seq_state_t state, state_nxt;

    logic [BCW-1:0]        byte_cnt;
    logic                  load;
    logic                  unp_busy;
    logic                  unp_ready;
    logic                  unp_last;
    logic [2:0]            bit_idx;
    logic                  unp_bit;
    logic                  last_byte;
    logic                  wd_expire;
    logic [PIX_ADDR_W-1:0] loader_addr;

    snn_byte_unpacker u_unpacker (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .data     (rx_data),
        .ack      (rx_ack),
        .busy     (unp_busy),
        .ready    (unp_ready),
        .last_bit (unp_last),
        .bit_idx  (bit_idx),
        .bit_data (unp_bit)
    );

    assign last_byte = (byte_cnt == BCW'(NUM_BYTES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (rx_rdy) begin
                    load      = 1'b1;
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                if (unp_last && last_byte) begin
                    state_nxt = START;
                end else if (rx_rdy && unp_ready) begin
                    load = 1'b1;
                end
            end
            START: state_nxt = WAIT_DONE;
            WAIT_DONE: begin
                if (core_done) begin
                    state_nxt = RESULT;
                end else if (wd_expire) begin
                    state_nxt = IDLE;
                end
            end
            RESULT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt <= '0;
        end else if (load) begin
            byte_cnt <= (state == IDLE) ? '0 : byte_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_digit <= '0;
        end else if (state == WAIT_DONE && core_done) begin
            result_digit <= core_digit;
        end
    end

`ifdef SNN_SEQ_TIMEOUT_EN
    localparam int unsigned WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [WD_W-1:0] wd_cnt;
    logic            wd_err;

    // Counter sits at zero outside WAIT_DONE, so it is clear on every entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt <= '0;
            wd_err <= 1'b0;
        end else begin
            wd_cnt <= (state == WAIT_DONE) ? wd_cnt + 1'b1 : '0;
            if (wd_expire) begin
                wd_err <= 1'b1;
            end
        end
    end

    assign wd_expire   = (state == WAIT_DONE) && !core_done && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
    assign timeout_err = wd_err;
`else
    assign wd_expire   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    assign loader_addr = (PIX_ADDR_W'(byte_cnt) << 3) | PIX_ADDR_W'(bit_idx);
    assign ram_addr    = (state == WAIT_DONE) ? core_addr : loader_addr;
    assign ram_we      = (state == LOAD) && unp_busy;
    assign ram_wdata   = unp_bit;
    assign core_start  = (state == START);
    assign result_vld  = (state == RESULT);
    assign busy        = (state != IDLE);

endmodule

// File: tb/tb_snn_frame_sequencer.sv
// Directed self-checking bench for snn_frame_sequencer (timeout case only with SNN_SEQ_TIMEOUT_EN).
`timescale 1ns/1ps
module tb_snn_frame_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_rdy = 1'b0;
    logic [7:0] rx_data = '0;
    logic       rx_ack;
    logic       core_start;
    logic       core_done = 1'b0;
    logic [3:0] core_digit = '0;
    logic [9:0] core_addr = '0;
    logic [9:0] ram_addr;
    logic       ram_we;
    logic       ram_wdata;
    logic       result_vld;
    logic [3:0] result_digit;
    logic       busy;
    logic       timeout_err;

    always #5 clk = ~clk;

    snn_frame_sequencer #(
        .NUM_PIXELS(784)
`ifdef SNN_SEQ_TIMEOUT_EN
        , .TIMEOUT_CYCLES(64)
`endif
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_rdy       (rx_rdy),
        .rx_data      (rx_data),
        .rx_ack       (rx_ack),
        .core_start   (core_start),
        .core_done    (core_done),
        .core_digit   (core_digit),
        .core_addr    (core_addr),
        .ram_addr     (ram_addr),
        .ram_we       (ram_we),
        .ram_wdata    (ram_wdata),
        .result_vld   (result_vld),
        .result_digit (result_digit),
        .busy         (busy),
        .timeout_err  (timeout_err)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // RAM model and event counters, sampled on the falling edge.
    logic        mem [0:783];
    logic [7:0]  frame [0:97];
    int unsigned cyc = 0;
    int unsigned wr_cnt = 0, addr_err = 0, ack_cnt = 0, start_cnt = 0, vld_cnt = 0;
    int unsigned last_wr_cyc = 0, start_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (ram_we) begin
                if (ram_addr < 10'd784) mem[ram_addr] = ram_wdata;
                if (ram_addr != wr_cnt[9:0] || wr_cnt >= 784) addr_err++;
                wr_cnt++;
                last_wr_cyc = cyc;
            end
            if (rx_ack) ack_cnt++;
            if (core_start) begin
                start_cnt++;
                start_cyc = cyc;
            end
            if (result_vld) vld_cnt++;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_counts();
        wr_cnt = 0; addr_err = 0; ack_cnt = 0; start_cnt = 0; vld_cnt = 0;
    endtask

    task automatic wait_sig(input int which, input int unsigned budget, output bit ok);
        int unsigned w = 0;
        ok = 1'b0;
        while (w < budget) begin
            case (which)
                0: ok = core_start;
                1: ok = result_vld;
                default: ok = timeout_err;
            endcase
            if (ok) break;
            tick();
            w++;
        end
    endtask

    // rx_rdy stays high across bytes; data advances on each observed ack.
    task automatic send_bytes(input int unsigned upto);
        for (int unsigned i = 0; i < upto; i++) begin
            int unsigned w = 0;
            rx_rdy  = 1'b1;
            rx_data = frame[i];
            do begin
                tick();
                w++;
            end while (!rx_ack && w < 50);
            if (!rx_ack) begin
                check("rx_ack_wait", {31'd0, rx_ack}, 32'd1);
                break;
            end
        end
        rx_rdy = 1'b0;
    endtask

    task automatic run_frame(input int unsigned delay, input logic [3:0] digit);
        bit ok;
        clear_counts();
        send_bytes(98);
        wait_sig(0, 50, ok);
        check("core_start_seen", {31'd0, ok}, 32'd1);
        repeat (delay) tick();
        core_digit = digit;
        core_done  = 1'b1;
        tick();
        core_done  = 1'b0;
        wait_sig(1, 10, ok);
        check("result_vld_seen", {31'd0, ok}, 32'd1);
        tick();
    endtask

    function automatic int unsigned data_errs();
        int unsigned e = 0;
        for (int unsigned a = 0; a < 784; a++)
            if (mem[a] !== frame[a / 8][a % 8]) e++;
        return e;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        bit          ok;
        int unsigned ones;
        int unsigned snap;
        logic [7:0]  b0;

        repeat (3) tick();
        check("rst_outputs", {25'd0, rx_ack, core_start, ram_we, ram_wdata, result_vld, busy, timeout_err}, 32'd0);
        check("rst_result_digit", {28'd0, result_digit}, 32'd0);
        rst = 1'b0;
        tick();

        // Frame of zeros, digit 7 after 100 cycles.
        for (int unsigned i = 0; i < 98; i++) frame[i] = 8'h00;
        for (int unsigned a = 0; a < 784; a++) mem[a] = 1'b1;
        run_frame(100, 4'd7);
        check("f1_writes", wr_cnt, 784);
        check("f1_addr_seq", addr_err, 0);
        check("f1_data", data_errs(), 0);
        check("f1_acks", ack_cnt, 98);
        check("f1_start_cnt", start_cnt, 1);
        check("f1_start_after_last_wr", start_cyc - last_wr_cyc, 1);
        check("f1_vld_cnt", vld_cnt, 1);
        check("f1_digit", {28'd0, result_digit}, 7);
        check("f1_busy_after", {31'd0, busy}, 0);

        // 0xA5 then 0xFF; done arrives in the first WAIT_DONE cycle.
        frame[0] = 8'hA5;
        for (int unsigned i = 1; i < 98; i++) frame[i] = 8'hFF;
        run_frame(1, 4'd3);
        for (int unsigned k = 0; k < 8; k++) b0[k] = mem[k];
        ones = 0;
        for (int unsigned a = 8; a < 784; a++) if (mem[a] === 1'b1) ones++;
        check("f2_byte0_bits", {24'd0, b0}, 32'hA5);
        check("f2_ones_8_783", ones, 776);
        check("f2_addr_seq", addr_err, 0);
        check("f2_acks", ack_cnt, 98);
        check("f2_digit", {28'd0, result_digit}, 3);
        check("f2_vld_cnt", vld_cnt, 1);

        // WAIT_DONE address mux and rx_rdy ignored.
        for (int unsigned i = 0; i < 98; i++) frame[i] = 8'(i * 29 + 3);
        clear_counts();
        send_bytes(98);
        wait_sig(0, 50, ok);
        check("f3_core_start_seen", {31'd0, ok}, 32'd1);
        tick();
        core_addr = 10'h2AB;
        tick();
        check("wait_ram_addr", {22'd0, ram_addr}, 32'h2AB);
        check("wait_ram_we", {31'd0, ram_we}, 0);
        check("wait_busy", {31'd0, busy}, 1);
        snap   = ack_cnt;
        rx_rdy = 1'b1;
        rx_data = 8'h5A;
        repeat (5) tick();
        rx_rdy = 1'b0;
        check("wait_no_ack", ack_cnt - snap, 0);
        check("f3_data", data_errs(), 0);
        core_digit = 4'd5;
        core_done  = 1'b1;
        tick();
        core_done  = 1'b0;
        wait_sig(1, 10, ok);
        check("f3_vld_seen", {31'd0, ok}, 1);
        tick();
        check("f3_digit", {28'd0, result_digit}, 5);

        // core_done while idle is ignored.
        snap = vld_cnt;
        core_digit = 4'd9;
        core_done  = 1'b1;
        tick();
        core_done  = 1'b0;
        repeat (3) tick();
        check("idle_done_no_vld", vld_cnt - snap, 0);
        check("idle_done_digit", {28'd0, result_digit}, 5);
        check("idle_done_busy", {31'd0, busy}, 0);

        // Reset mid-frame after byte 40, then a complete fresh frame.
        for (int unsigned i = 0; i < 98; i++) frame[i] = 8'hFF ^ 8'(i);
        clear_counts();
        send_bytes(40);
        check("mid_acks", ack_cnt, 40);
        check("mid_we_before_rst", {31'd0, ram_we}, 1);
        rst = 1'b1;
        #2;
        check("mid_rst_outputs", {25'd0, rx_ack, core_start, ram_we, ram_wdata, result_vld, busy, timeout_err}, 0);
        check("mid_rst_digit", {28'd0, result_digit}, 0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        for (int unsigned i = 0; i < 98; i++) frame[i] = 8'(i * 37 + 11);
        run_frame(20, 4'd2);
        check("f4_writes", wr_cnt, 784);
        check("f4_addr_seq", addr_err, 0);
        check("f4_data", data_errs(), 0);
        check("f4_digit", {28'd0, result_digit}, 2);
        check("f4_vld_cnt", vld_cnt, 1);
        check("f4_timeout_err", {31'd0, timeout_err}, 0);

`ifdef SNN_SEQ_TIMEOUT_EN
        // Core never answers: watchdog fires after 64 WAIT_DONE cycles.
        begin
            int unsigned n = 0;
            clear_counts();
            send_bytes(98);
            wait_sig(0, 50, ok);
            check("to_core_start_seen", {31'd0, ok}, 1);
            while (!timeout_err && n < 200) begin
                tick();
                n++;
            end
            check("to_cycles_from_start", n, 65);
            check("to_err", {31'd0, timeout_err}, 1);
            check("to_busy", {31'd0, busy}, 0);
            check("to_no_vld", vld_cnt, 0);
            repeat (3) tick();
            check("to_sticky", {31'd0, timeout_err}, 1);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
